// File: rtl/local_store_pkg.sv
// Shared constants and types for the SPU local store and its load-return pipe.
package local_store_pkg;

    localparam int LS_ADDR_WIDTH   = 15;
    localparam int LS_LINE_BITS    = 128;
    localparam int LS_LINES        = 2048;
    localparam int LS_RT_WIDTH     = 7;
    localparam int LS_READ_LATENCY = 6;

    typedef enum logic {
        LS_CLEAR,
        LS_READY
    } ls_state_t;

    typedef struct packed {
        logic                    valid;
        logic [0:LS_LINE_BITS-1] data;
        logic [0:LS_RT_WIDTH-1]  rt;
    } ls_resp_t;

endpackage

// File: rtl/ls_delay_pipe.sv
// Fixed-depth shift pipe for load responses; payload only advances behind a valid
// entry, so the last stage holds the most recent returned load.
module ls_delay_pipe
    import local_store_pkg::*;
#(
    parameter int DEPTH = 5
) (
    input  logic     clock,
    input  logic     reset,
    input  ls_resp_t resp_in,
    output ls_resp_t resp_out
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign resp_out = resp_in;
        end else begin : g_shift
            ls_resp_t stage [DEPTH];

            // Flush drops in-flight loads and zeroes the held payload.
            always_ff @(posedge clock) begin
                if (!reset) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage[i] <= '0;
                    end
                end else begin
                    stage[0].valid <= resp_in.valid;
                    if (resp_in.valid) begin
                        stage[0].data <= resp_in.data;
                        stage[0].rt   <= resp_in.rt;
                    end
                    for (int i = 1; i < DEPTH; i++) begin
                        stage[i].valid <= stage[i-1].valid;
                        if (stage[i-1].valid) begin
                            stage[i].data <= stage[i-1].data;
                            stage[i].rt   <= stage[i-1].rt;
                        end
                    end
                end
            end

            assign resp_out = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/local_store.sv
// 32 KB SPU local store: single-port quadword array with post-reset zero fill
// and a fixed-latency load return path tagged with the destination register.
module local_store #(
    parameter int LS_ADDR_WIDTH  = 15,
    parameter int LINE_BITS      = 128,
    parameter int READ_LATENCY   = 6,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                     clock,
    input  logic                     reset,
    output logic                     ls_ready,
    input  logic                     ls_req_valid,
    input  logic                     ls_wr_en,
    input  logic [0:LS_ADDR_WIDTH-1] ls_address_input,
    input  logic [0:LINE_BITS-1]     ls_data_input,
    input  logic [0:6]               rt_address_input,
    output logic [0:LINE_BITS-1]     ls_data_output,
    output logic                     ls_data_valid,
    output logic [0:6]               rt_address_output
);
    import local_store_pkg::*;

    localparam int IDX_W = LS_ADDR_WIDTH - 4;
    localparam int LINES = 2 ** IDX_W;

    ls_state_t            state;
    ls_state_t            next_state;
    logic [IDX_W-1:0]     clear_idx;
    logic [0:IDX_W-1]     line_idx;
    logic                 accept;
    logic                 clearing;
    logic                 unused_addr_bits;
    logic [0:LINE_BITS-1] mem [LINES];
    ls_resp_t             read_q;
    ls_resp_t             pipe_out;

    assign line_idx         = ls_address_input[0:IDX_W-1];
    assign unused_addr_bits = &{1'b0, ls_address_input[IDX_W:LS_ADDR_WIDTH-1]};
    assign accept           = reset && ls_ready && ls_req_valid;
    assign clearing         = reset && (state == LS_CLEAR);

    // ls_ready is registered from next_state so it rises on the edge that
    // writes the final clear line.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (CLEAR_ON_RESET) begin
                state <= LS_CLEAR;
            end else begin
                state <= LS_READY;
            end
            clear_idx <= '0;
            ls_ready  <= 1'b0;
        end else begin
            state    <= next_state;
            ls_ready <= (next_state == LS_READY);
            if (state == LS_CLEAR) begin
                clear_idx <= clear_idx + 1'b1;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            LS_CLEAR: begin
                if (clear_idx == {IDX_W{1'b1}}) begin
                    next_state = LS_READY;
                end
            end
            LS_READY: next_state = LS_READY;
            default:  next_state = LS_CLEAR;
        endcase
    end

    // No request is accepted while clearing, so the clear owns the write port.
    always_ff @(posedge clock) begin
        if (clearing) begin
            mem[clear_idx] <= '0;
        end else if (accept && ls_wr_en) begin
            mem[line_idx] <= ls_data_input;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            read_q <= '0;
        end else begin
            read_q.valid <= accept && !ls_wr_en;
            if (accept && !ls_wr_en) begin
                read_q.data <= mem[line_idx];
                read_q.rt   <= rt_address_input;
            end
        end
    end

    ls_delay_pipe #(
        .DEPTH (READ_LATENCY - 1)
    ) u_delay_pipe (
        .clock    (clock),
        .reset    (reset),
        .resp_in  (read_q),
        .resp_out (pipe_out)
    );

    assign ls_data_valid     = pipe_out.valid;
    assign ls_data_output    = pipe_out.data;
    assign rt_address_output = pipe_out.rt;

endmodule

// File: tb/tb_local_store.sv
// Self-checking bench for local_store: a transaction-level model checked every
// cycle, plus literal expectations for the directed scenarios.
module tb_local_store;

    localparam int LAT   = 6;
    localparam int LINES = 2048;

    logic         clock;
    logic         reset;
    logic         ls_ready;
    logic         ls_req_valid;
    logic         ls_wr_en;
    logic [0:14]  ls_address_input;
    logic [0:127] ls_data_input;
    logic [0:6]   rt_address_input;
    logic [0:127] ls_data_output;
    logic         ls_data_valid;
    logic [0:6]   rt_address_output;

    typedef struct {
        int           due;
        logic [0:127] data;
        logic [0:6]   rt;
    } pending_t;

    typedef struct {
        int           cyc;
        logic [0:127] data;
        logic [0:6]   rt;
    } seen_t;

    logic [0:127] model_mem [LINES];
    pending_t     pending[$];
    seen_t        seen[$];
    bit           model_ready = 1'b0;
    int           clear_left  = LINES;
    int           cyc         = 0;
    int           checks      = 0;
    int           failures    = 0;

    local_store dut (
        .clock             (clock),
        .reset             (reset),
        .ls_ready          (ls_ready),
        .ls_req_valid      (ls_req_valid),
        .ls_wr_en          (ls_wr_en),
        .ls_address_input  (ls_address_input),
        .ls_data_input     (ls_data_input),
        .rt_address_input  (rt_address_input),
        .ls_data_output    (ls_data_output),
        .ls_data_valid     (ls_data_valid),
        .rt_address_output (rt_address_output)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Model: a request is honoured only when ready; loads return LAT cycles
    // later with the array contents seen at acceptance; a clear takes LINES cycles.
    always @(posedge clock) begin
        int idx;
        cyc++;
        if (!reset) begin
            model_ready = 1'b0;
            clear_left  = LINES;
            pending.delete();
        end else begin
            if (model_ready && ls_req_valid) begin
                idx = int'(ls_address_input >> 4);
                if (ls_wr_en) begin
                    model_mem[idx] = ls_data_input;
                end else begin
                    pending.push_back('{cyc + LAT - 1, model_mem[idx], rt_address_input});
                end
            end
            if (!model_ready) begin
                clear_left--;
                if (clear_left == 0) begin
                    foreach (model_mem[i]) model_mem[i] = '0;
                    model_ready = 1'b1;
                end
            end
        end
    end

    always @(negedge clock) begin
        bit exp_valid;
        exp_valid = (pending.size() > 0) && (pending[0].due == cyc);
        checkOutput("ls_ready", 128'(ls_ready), 128'(model_ready));
        checkOutput("ls_data_valid", 128'(ls_data_valid), 128'(exp_valid));
        if (ls_data_valid === 1'b1) begin
            seen.push_back('{cyc, ls_data_output, rt_address_output});
        end
        if (exp_valid) begin
            checkOutput("ls_data_output", ls_data_output, pending[0].data);
            checkOutput("rt_address_output", 128'(rt_address_output), 128'(pending[0].rt));
            void'(pending.pop_front());
        end
    end

    task automatic applyStimulus(input logic rst, input logic req, input logic wr,
                                 input logic [14:0] addr, input logic [127:0] data,
                                 input logic [6:0] rt);
        reset            = rst;
        ls_req_valid     = req;
        ls_wr_en         = wr;
        ls_address_input = addr;
        ls_data_input    = data;
        rt_address_input = rt;
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b1, 1'b0, 1'b0, 15'h0, 128'h0, 7'h0);
    endtask

    task automatic store(input logic [14:0] addr, input logic [127:0] data);
        applyStimulus(1'b1, 1'b1, 1'b1, addr, data, 7'h0);
    endtask

    task automatic load(input logic [14:0] addr, input logic [6:0] rt, output int edge_no);
        applyStimulus(1'b1, 1'b1, 1'b0, addr, 128'h0, rt);
        edge_no = cyc;
    endtask

    task automatic waitReady(input string name, input int expected);
        int n;
        n = 0;
        while (ls_ready !== 1'b1 && n < 5000) begin
            idle(1);
            n++;
        end
        checkOutput(name, 128'(n), 128'(expected));
    endtask

    task automatic checkLoad(input string name, input logic [6:0] rt,
                             input logic [127:0] exp_data, input int exp_cyc);
        int hit;
        hit = -1;
        foreach (seen[i]) if (seen[i].rt == rt && hit < 0) hit = i;
        if (hit < 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s: got no response, expected tag %0d", name, rt);
        end else begin
            checkOutput({name, "_data"}, seen[hit].data, exp_data);
            checkOutput({name, "_cycle"}, 128'(seen[hit].cyc), 128'(exp_cyc));
        end
    endtask

    task automatic checkAbsent(input string name, input logic [6:0] rt);
        int cnt;
        cnt = 0;
        foreach (seen[i]) if (seen[i].rt == rt) cnt++;
        checkOutput(name, 128'(cnt), 128'(0));
    endtask

    initial begin
        int e1, e2, e3, e4, e5, e6, e7, e8, e9;
        foreach (model_mem[i]) model_mem[i] = '0;
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 15'h0, 128'h0, 7'h0);
        $display("[TB] reset released, waiting for zero fill");
        waitReady("clear_cycles", 2048);

        load(15'h7FF0, 7'd20, e1);
        idle(8);
        checkLoad("t1_load_7ff0", 7'd20, 128'h0, e1 + 5);

        store(15'h0010, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
        load(15'h0010, 7'd5, e2);
        idle(8);
        checkLoad("t2_store_load", 7'd5, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, e2 + 5);

        store(15'h0020, 128'hA5);
        load(15'h002F, 7'd6, e3);
        idle(8);
        checkLoad("t3_low_nibble", 7'd6, 128'hA5, e3 + 5);

        store(15'h0100, 128'h1);
        store(15'h0110, 128'h2);
        store(15'h0120, 128'h3);
        load(15'h0100, 7'd1, e4);
        load(15'h0110, 7'd2, e9);
        load(15'h0120, 7'd3, e9);
        idle(8);
        checkLoad("t4_first", 7'd1, 128'h1, e4 + 5);
        checkLoad("t4_second", 7'd2, 128'h2, e4 + 6);
        checkLoad("t4_third", 7'd3, 128'h3, e4 + 7);

        store(15'h0040, 128'h11);
        load(15'h0040, 7'd9, e5);
        store(15'h0040, 128'h22);
        load(15'h0040, 7'd10, e9);
        idle(8);
        checkLoad("t5_snapshot", 7'd9, 128'h11, e5 + 5);
        checkLoad("t5_after_store", 7'd10, 128'h22, e5 + 7);

        load(15'h0010, 7'd12, e6);
        idle(1);
        applyStimulus(1'b0, 1'b0, 1'b0, 15'h0, 128'h0, 7'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 15'h0010, 128'h0, 7'd13);
        applyStimulus(1'b1, 1'b1, 1'b1, 15'h0030, 128'hBEEF, 7'h0);
        waitReady("reclear_cycles", 2046);
        load(15'h0010, 7'd14, e7);
        load(15'h0030, 7'd15, e8);
        idle(8);
        checkAbsent("t6_flushed_load", 7'd12);
        checkAbsent("t6_dropped_load", 7'd13);
        checkLoad("t6_zeroed", 7'd14, 128'h0, e7 + 5);
        checkLoad("t6_dropped_store", 7'd15, 128'h0, e8 + 5);
        checkOutput("pending_drained", 128'(pending.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
